// File: rtl/scale_cfg_if.sv
// Host-side and scaltop-side signals of the scale configuration sequencer.
// master = host/driver side, slave = sequencer side.
interface scale_cfg_if;
    // Write handshake: wr_en is a one-cycle strobe with no backpressure. An entry is taken
    // on the clk_sys edge that samples wr_en=1 only while the sequencer is idle and not full;
    // any other strobe is discarded and latched into ovf_err.
    logic        wr_en;
    logic [4:0]  wr_choice;
    logic [15:0] wr_data;
    logic        cmd_go;
    logic        cmd_abort;
    logic [4:0]  scalechoice;
    logic [15:0] scaledatain;
    logic        scaleload;
    logic        scalstart;
    logic        pn_change;
    logic        busy;
    logic [6:0]  fifo_count;
    logic        ovf_err;

    modport master (
        output wr_en, wr_choice, wr_data, cmd_go, cmd_abort,
        input  scalechoice, scaledatain, scaleload, scalstart, pn_change, busy, fifo_count, ovf_err
    );

    modport slave (
        input  wr_en, wr_choice, wr_data, cmd_go, cmd_abort,
        output scalechoice, scaledatain, scaleload, scalstart, pn_change, busy, fifo_count, ovf_err
    );
endinterface

// File: rtl/scale_cfg_sequencer.sv
// Replays host-queued (choice, data) pairs to scaltop as scaleload transactions, then scalstart.
// Optional macro SCALE_PN_TOGGLE_EN: pn_change pulses with scalstart on every second sequence.
module scale_cfg_sequencer #(
    parameter int DEPTH  = 16,
    parameter int LOAD_W = 2,
    parameter int GAP_W  = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    scale_cfg_if.slave bus,
    output logic [2:0] o_dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOAD  = 3'd2,
        S_GAP   = 3'd3,
        S_START = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [6:0]    r_count;
    logic          r_ovf;
    logic [CW-1:0] r_cnt;
    logic [20:0]   r_mem [DEPTH];
    logic [20:0]   r_hold;
    logic          w_wr_ok;
    logic          w_pop;
    logic          w_cnt_done;

    assign w_wr_ok = bus.wr_en && !bus.cmd_abort && (r_state == S_IDLE) && (r_count < 7'(DEPTH));
    assign w_pop   = (r_state == S_SETUP) && !bus.cmd_abort;

    always_comb begin
        w_cnt_done = 1'b0;
        if (r_state == S_LOAD) w_cnt_done = (r_cnt == CW'(LOAD_W - 1));
        if (r_state == S_GAP)  w_cnt_done = (r_cnt == CW'(GAP_W - 1));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // A write in the same cycle as cmd_go counts toward the go decision.
    always_comb begin
        w_next = r_state;
        if (bus.cmd_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.cmd_go) w_next = (r_count != 7'd0 || w_wr_ok) ? S_SETUP : S_START;
                S_SETUP: w_next = S_LOAD;
                S_LOAD:  if (w_cnt_done) w_next = S_GAP;
                S_GAP:   if (w_cnt_done) w_next = (r_count != 7'd0) ? S_SETUP : S_START;
                S_START: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || w_next != r_state)                r_cnt <= '0;
        else if (r_state == S_LOAD || r_state == S_GAP) r_cnt <= r_cnt + 1'b1;
        else                                           r_cnt <= '0;
    end

    always_ff @(posedge clk_sys) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= {bus.wr_choice, bus.wr_data};
    end

    // Full and empty are told apart by r_count; pointers simply wrap.
    always_ff @(posedge clk_sys) begin
        if (reset || bus.cmd_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_hold   <= '0;
        end else begin
            if (bus.wr_en && !w_wr_ok) r_ovf <= 1'b1;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 7'd1;
            end else if (w_pop) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 7'd1;
            end
        end
    end

    // SETUP shows the head entry directly so data leads scaleload by one cycle.
    always_comb begin
        bus.scalechoice = '0;
        bus.scaledatain = '0;
        case (r_state)
            S_SETUP:       {bus.scalechoice, bus.scaledatain} = r_mem[r_rd_ptr];
            S_LOAD, S_GAP: {bus.scalechoice, bus.scaledatain} = r_hold;
            default:       ;
        endcase
    end

    assign bus.scaleload  = (r_state == S_LOAD);
    assign bus.scalstart  = (r_state == S_START);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.fifo_count = r_count;
    assign bus.ovf_err    = r_ovf;
    assign o_dbg_state    = r_state;

`ifdef SCALE_PN_TOGGLE_EN
    logic r_parity;

    always_ff @(posedge clk_sys) begin
        if (reset || bus.cmd_abort)  r_parity <= 1'b0;
        else if (r_state == S_START) r_parity <= ~r_parity;
    end

    assign bus.pn_change = (r_state == S_START) && r_parity;
`else
    assign bus.pn_change = 1'b0;
`endif
endmodule

// File: tb/tb_scale_cfg_sequencer.sv
// Bench for scale_cfg_sequencer: status vector table, directed corner sequences and
// randomized sequences scored against a transaction-timing model.
module tb_scale_cfg_sequencer;
    localparam int DEPTH  = 16;
    localparam int LOAD_W = 2;
    localparam int GAP_W  = 2;
    localparam int P      = 1 + LOAD_W + GAP_W;
    localparam int LW     = 53;
    localparam int SW     = 33;

    typedef struct {
        logic       wr;
        logic       go;
        logic       ab;
        logic       chk_cnt;
        logic [6:0] cnt;
        logic       ovf;
        logic       busy;
        logic       start;
        logic       load;
    } vec_t;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic [2:0] dbg_state;

    scale_cfg_if bus();

    scale_cfg_sequencer #(.DEPTH(DEPTH), .LOAD_W(LOAD_W), .GAP_W(GAP_W)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk_sys = ~clk_sys;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    bit            mon_en   = 1'b0;
    logic [LW-1:0] exp_load_q[$];
    logic [SW-1:0] exp_start_q[$];
    logic [20:0]   mq[$];
    bit            m_ovf    = 1'b0;
    int            m_seq    = 0;
    vec_t          vt[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every cycle a load/start is seen it must be the next one the model scheduled.
    task automatic sample();
        logic [LW-1:0] e_l;
        logic [SW-1:0] e_s;
        if (!mon_en) return;
        if (bus.scaleload) begin
            e_l = (exp_load_q.size() != 0) ? exp_load_q.pop_front() : '1;
            chk("load_event", {32'(cyc), bus.scalechoice, bus.scaledatain}, e_l);
        end
        if (bus.scalstart) begin
            e_s = (exp_start_q.size() != 0) ? exp_start_q.pop_front() : '1;
            chk("start_event", {32'(cyc), bus.pn_change}, e_s);
        end
        chk("pn_without_start", bus.pn_change & ~bus.scalstart, 0);
    endtask

    task automatic tick();
        @(negedge clk_sys);
        sample();
        @(posedge clk_sys);
        cyc++;
        #1;
    endtask

    task automatic idle_in();
        bus.wr_en     = 1'b0;
        bus.cmd_go    = 1'b0;
        bus.cmd_abort = 1'b0;
    endtask

    function automatic vec_t v(bit wr, bit go, bit ab, bit cc, int cnt, bit ovf, bit bsy, bit st, bit ld);
        vec_t r;
        r.wr = wr; r.go = go; r.ab = ab; r.chk_cnt = cc; r.cnt = 7'(cnt);
        r.ovf = ovf; r.busy = bsy; r.start = st; r.load = ld;
        return r;
    endfunction

    function automatic void model_write(input logic [4:0] ch, input logic [15:0] d);
        if (mq.size() < DEPTH) mq.push_back({ch, d});
        else                   m_ovf = 1'b1;
    endfunction

    // Entry k loads during cycles g+2+k*P .. +LOAD_W-1; start lands at g+1+N*P.
    function automatic void sched_go(input int g);
        int n = mq.size();
        bit pn;
        for (int k = 0; k < n; k++)
            for (int t = 0; t < LOAD_W; t++)
                exp_load_q.push_back({32'(g + 2 + k * P + t), mq[k]});
`ifdef SCALE_PN_TOGGLE_EN
        pn = (m_seq % 2) == 1;
`else
        pn = 1'b0;
`endif
        exp_start_q.push_back({32'(g + 1 + n * P), pn});
        m_seq++;
        mq.delete();
    endfunction

    function automatic void prune(input int a);
        logic [LW-1:0] kl[$];
        logic [SW-1:0] ks[$];
        foreach (exp_load_q[i])  if (int'(exp_load_q[i][52:21]) <= a) kl.push_back(exp_load_q[i]);
        foreach (exp_start_q[i]) if (int'(exp_start_q[i][32:1]) <= a) ks.push_back(exp_start_q[i]);
        exp_load_q  = kl;
        exp_start_q = ks;
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_seq = 0;
    endfunction

    task automatic push(input logic [4:0] ch, input logic [15:0] d);
        bus.wr_en = 1'b1; bus.wr_choice = ch; bus.wr_data = d;
        model_write(ch, d);
        tick();
        idle_in();
    endtask

    task automatic do_seq(input bit wr_same, input bit bw, input int ab_off);
        int g;
        int budget;
        logic [4:0]  ch;
        logic [15:0] d;
        if (wr_same) begin
            ch = 5'($urandom); d = 16'($urandom);
            bus.wr_en = 1'b1; bus.wr_choice = ch; bus.wr_data = d;
            model_write(ch, d);
        end
        g = cyc;
        bus.cmd_go = 1'b1;
        sched_go(g);
        tick();
        idle_in();
        budget = 0;
        while (bus.busy && budget < 1000) begin
            if (bw && cyc == g + 1) begin
                bus.wr_en = 1'b1; bus.wr_choice = 5'($urandom); bus.wr_data = 16'($urandom);
                m_ovf = 1'b1;
            end
            if (ab_off != 0 && cyc == g + ab_off) begin
                bus.cmd_abort = 1'b1;
                prune(cyc);
                model_clear();
            end
            tick();
            idle_in();
            budget++;
        end
        chk("seq_finished", budget < 1000, 1);
        chk("seq_loads_missing", exp_load_q.size(), 0);
        chk("seq_start_missing", exp_start_q.size(), 0);
        chk("seq_fifo_count", bus.fifo_count, mq.size());
        chk("seq_ovf_err", bus.ovf_err, m_ovf);
    endtask

    initial begin
        int g;
        int n;
        idle_in();
        bus.wr_choice = '0;
        bus.wr_data   = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_scaleload", bus.scaleload, 0);
        chk("rst_scalstart", bus.scalstart, 0);
        chk("rst_pn_change", bus.pn_change, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_ovf_err", bus.ovf_err, 0);
        chk("rst_scalechoice", bus.scalechoice, 0);
        chk("rst_scaledatain", bus.scaledatain, 0);

        //         wr go ab cc cnt ovf bsy st ld
        vt[0]  = v(1, 0, 0, 1, 1, 0, 0, 0, 0);
        vt[1]  = v(1, 0, 0, 1, 2, 0, 0, 0, 0);
        vt[2]  = v(1, 1, 1, 1, 0, 0, 0, 0, 0);
        vt[3]  = v(0, 1, 0, 1, 0, 0, 1, 1, 0);
        vt[4]  = v(1, 0, 0, 1, 0, 1, 0, 0, 0);
        vt[5]  = v(1, 0, 0, 1, 1, 1, 0, 0, 0);
        vt[6]  = v(0, 0, 1, 1, 0, 0, 0, 0, 0);
        vt[7]  = v(1, 1, 0, 0, 0, 0, 1, 0, 0);
        vt[8]  = v(0, 1, 0, 1, 0, 0, 1, 0, 1);
        vt[9]  = v(0, 0, 1, 1, 0, 0, 0, 0, 0);
        vt[10] = v(0, 1, 0, 1, 0, 0, 1, 1, 0);
        vt[11] = v(0, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[12] = v(0, 0, 1, 1, 0, 0, 0, 0, 0);
        foreach (vt[i]) begin
            bus.wr_en = vt[i].wr; bus.cmd_go = vt[i].go; bus.cmd_abort = vt[i].ab;
            bus.wr_choice = 5'($urandom); bus.wr_data = 16'($urandom);
            tick();
            idle_in();
            if (vt[i].chk_cnt) chk($sformatf("vec%0d_count", i), bus.fifo_count, vt[i].cnt);
            chk($sformatf("vec%0d_ovf", i), bus.ovf_err, vt[i].ovf);
            chk($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
            chk($sformatf("vec%0d_start", i), bus.scalstart, vt[i].start);
            chk($sformatf("vec%0d_load", i), bus.scaleload, vt[i].load);
        end
        model_clear();
        mon_en = 1'b1;

        // Two-entry replay.
        push(5'h03, 16'h1234);
        push(5'h11, 16'hABCD);
        do_seq(1'b0, 1'b0, 0);

        // Go with nothing queued.
        do_seq(1'b0, 1'b0, 0);

        // Overfill: the DEPTH+1th write is dropped.
        for (int i = 0; i < DEPTH + 1; i++) push(5'(i), 16'(16'hC000 + i));
        chk("full_fifo_count", bus.fifo_count, DEPTH);
        chk("full_ovf_err", bus.ovf_err, 1);
        do_seq(1'b0, 1'b0, 0);

        // Abort in the first GAP cycle of the second entry, after a busy write raised ovf_err.
        push(5'h05, 16'h0505);
        push(5'h06, 16'h0606);
        do_seq(1'b0, 1'b1, 2 + P + LOAD_W);
        chk("abort_busy", bus.busy, 0);

        // Reset held for 3 cycles in the first LOAD.
        push(5'h07, 16'h0F0F);
        push(5'h1A, 16'h5555);
        g = cyc;
        bus.cmd_go = 1'b1;
        sched_go(g);
        tick();
        idle_in();
        while (cyc < g + 2) tick();
        reset = 1'b1;
        prune(cyc);
        model_clear();
        repeat (3) tick();
        chk("midrst_scaleload", bus.scaleload, 0);
        chk("midrst_scalstart", bus.scalstart, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_fifo_count", bus.fifo_count, 0);
        chk("midrst_ovf_err", bus.ovf_err, 0);
        chk("midrst_data", {bus.scalechoice, bus.scaledatain}, 0);
        reset = 1'b0;
        repeat (3 * P) tick();
        chk("midrst_no_events", exp_load_q.size() + exp_start_q.size(), 0);

        // Four back-to-back sequences for pn_change parity.
        for (int s = 0; s < 4; s++) begin
            push(5'(s + 8), 16'(16'h4000 + s));
            do_seq(1'b0, 1'b0, 0);
        end

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, DEPTH + 2);
            for (int i = 0; i < n; i++) push(5'($urandom), 16'($urandom));
            chk("rnd_fifo_count", bus.fifo_count, mq.size());
            chk("rnd_ovf_err", bus.ovf_err, m_ovf);
            n = mq.size();
            if ($urandom_range(0, 3) == 0)
                do_seq($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(1, (n + 1) * P + 1));
            else
                do_seq($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
